// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo -- single-clock synchronous FIFO with registered read data.
//
// Parameters
//   DEPTH          number of storage entries (2..65535, any value, not only
//                  powers of two)
//   WIDTH          data width in bits
//
// Ports
//   i_clock        clock; all state updates on its rising edge
//   i_reset        asynchronous active-low reset
//   i_write        push request, accepted when the FIFO is not full
//   i_wdata        data to push, sampled with i_write
//   i_read         pop request, accepted when the FIFO is not empty
//   o_rdata        registered data of the most recently popped entry
//   o_empty        stored entry count is 0
//   o_almost_full  stored entry count is >= DEPTH-1
//   o_queued       stored entry count, zero-extended to 16 bits
//
// Status outputs come straight from the registered count, so a producer sees
// no combinational path from its own request back to the flags.
// ---------------------------------------------------------------------------
module fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_read,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic [15:0]      o_queued
);

  localparam int          PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] DEPTH_C  = 16'(DEPTH);
  localparam logic [15:0] AFULL_C  = 16'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]      count_q,  count_d;
  logic [WIDTH-1:0] rdata_q,  rdata_d;

  logic push_ok;
  logic pop_ok;

  // Acceptance looks only at the registered count: a push while full is
  // refused even when a pop frees a slot on the same edge, and a pop while
  // empty cannot see a word being pushed on that edge.
  assign push_ok = i_write && (count_q < DEPTH_C);
  assign pop_ok  = i_read  && (count_q != 16'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      rdata_d  = mem[rd_ptr_q];
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 16'd1;
      2'b01:   count_d = count_q - 16'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage has no reset so it can map onto RAM; stale contents are never
  // visible because the pointers and count are cleared. Writes are blocked
  // during reset so the array is untouched until operation begins.
  always_ff @(posedge i_clock) begin
    if (i_reset && push_ok) begin
      mem[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_rdata       = rdata_q;
  assign o_empty       = (count_q == 16'd0);
  assign o_almost_full = (count_q >= AFULL_C);
  assign o_queued      = count_q;

endmodule

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo -- directed bench for fifo at DEPTH=4, WIDTH=32.
// A table of per-edge vectors covers fill/drain, overflow, underflow and the
// simultaneous push/pop corners; hand-written sequences cover sustained
// push/pop with pointer wrap and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic             rd;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             afull;
  logic [15:0]      queued;

  int tests_run = 0;
  int tests_failed = 0;

  fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_write      (wr),
    .i_wdata      (wdata),
    .i_read       (rd),
    .o_rdata      (rdata),
    .o_empty      (empty),
    .o_almost_full(afull),
    .o_queued     (queued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] wdata;
    logic        read;
    logic [15:0] exp_queued;
    logic        exp_empty;
    logic        exp_afull;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] q, input logic e,
                           input logic af, input logic [31:0] d);
    check({tag, " queued"}, 32'(queued), 32'(q));
    check({tag, " empty"},  32'(empty),  32'(e));
    check({tag, " afull"},  32'(afull),  32'(af));
    check({tag, " rdata"},  rdata,       d);
  endtask

  // Drive at the falling edge, let the rising edge act, sample 1 time unit later.
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    @(negedge clk);
    wr = w; wdata = d; rd = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          write wdata         read  queued empty afull rdata
    vecs[0]  = '{1'b0, 32'h0,       1'b0, 16'd0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'hA1,      1'b0, 16'd1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'hA2,      1'b0, 16'd2, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'hA3,      1'b0, 16'd3, 1'b0, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,       1'b1, 16'd2, 1'b0, 1'b0, 32'hA1};
    vecs[5]  = '{1'b0, 32'h0,       1'b1, 16'd1, 1'b0, 1'b0, 32'hA2};
    vecs[6]  = '{1'b0, 32'h0,       1'b1, 16'd0, 1'b1, 1'b0, 32'hA3};
    vecs[7]  = '{1'b0, 32'h0,       1'b1, 16'd0, 1'b1, 1'b0, 32'hA3}; // pop empty
    vecs[8]  = '{1'b1, 32'h55,      1'b1, 16'd1, 1'b0, 1'b0, 32'hA3}; // pop empty + push
    vecs[9]  = '{1'b0, 32'h0,       1'b1, 16'd0, 1'b1, 1'b0, 32'h55};
    vecs[10] = '{1'b1, 32'hB0,      1'b0, 16'd1, 1'b0, 1'b0, 32'h55};
    vecs[11] = '{1'b1, 32'hB1,      1'b0, 16'd2, 1'b0, 1'b0, 32'h55};
    vecs[12] = '{1'b1, 32'hB2,      1'b0, 16'd3, 1'b0, 1'b1, 32'h55};
    vecs[13] = '{1'b1, 32'hB3,      1'b0, 16'd4, 1'b0, 1'b1, 32'h55};
    vecs[14] = '{1'b1, 32'hFF,      1'b0, 16'd4, 1'b0, 1'b1, 32'h55}; // push full lost
    vecs[15] = '{1'b1, 32'hEE,      1'b1, 16'd3, 1'b0, 1'b1, 32'hB0}; // push full + pop
    vecs[16] = '{1'b1, 32'hC0,      1'b1, 16'd3, 1'b0, 1'b1, 32'hB1}; // both at DEPTH-1
    vecs[17] = '{1'b0, 32'h0,       1'b1, 16'd2, 1'b0, 1'b0, 32'hB2};
    vecs[18] = '{1'b0, 32'h0,       1'b1, 16'd1, 1'b0, 1'b0, 32'hB3};
    vecs[19] = '{1'b0, 32'h0,       1'b1, 16'd0, 1'b1, 1'b0, 32'hC0};

    wr = 1'b0; wdata = '0; rd = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'd0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].write, vecs[i].wdata, vecs[i].read);
      $display("[TB] vec %0d w=%0b d=0x%0h r=%0b -> queued=%0d empty=%0b afull=%0b rdata=0x%0h",
               i, vecs[i].write, vecs[i].wdata, vecs[i].read, queued, empty, afull, rdata);
      check_all($sformatf("vec%0d", i), vecs[i].exp_queued, vecs[i].exp_empty,
                vecs[i].exp_afull, vecs[i].exp_rdata);
    end

    // Sustained push+pop at count 2: pointers wrap several times, order kept.
    step(1'b1, 32'hD0, 1'b0);
    step(1'b1, 32'hD1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hD2 + 32'(i), 1'b1);
      $display("[TB] stream %0d -> queued=%0d rdata=0x%0h", i, queued, rdata);
      check($sformatf("stream%0d rdata", i), rdata, 32'hD0 + 32'(i));
      check($sformatf("stream%0d queued", i), 32'(queued), 32'd2);
    end

    // Three entries stored, then reset between edges.
    step(1'b1, 32'hE0, 1'b0);
    check("pre-reset queued", 32'(queued), 32'd3);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset -> queued=%0d empty=%0b rdata=0x%0h", queued, empty, rdata);
    check_all("async reset", 16'd0, 1'b1, 1'b0, 32'h0);

    // Requests during reset are ignored.
    wr = 1'b1; wdata = 32'h77; rd = 1'b1;
    @(posedge clk);
    #1;
    check_all("req in reset", 16'd0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wr = 1'b0; rd = 1'b0;

    // Normal operation after release: old entries are gone.
    step(1'b1, 32'h99, 1'b0);
    check("post-reset push queued", 32'(queued), 32'd1);
    step(1'b0, 32'h0, 1'b1);
    $display("[TB] post-reset pop -> queued=%0d rdata=0x%0h", queued, rdata);
    check_all("post-reset pop", 16'd0, 1'b1, 1'b0, 32'h99);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of storage entries (legal range 2..65535, not restricted to powers of two).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-003 i_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 i_write  input  1  push request; sampled on the rising edge.
REQ-006 i_wdata  input  WIDTH  data to push; sampled with i_write.
REQ-007 i_read  input  1  pop request; sampled on the rising edge.
REQ-008 o_rdata  output  WIDTH  registered data of the most recently popped entry.
REQ-009 o_empty  output  1  high when the stored entry count is 0.
REQ-010 o_almost_full  output  1  high when the stored entry count is >= DEPTH-1.
REQ-011 o_queued  output  16  number of entries currently stored, zero-extended.

Function
REQ-012 Storage SHALL be a DEPTH x WIDTH array with a write pointer, a read pointer and an entry counter, all registered.
REQ-013 A push SHALL be accepted on a rising edge when i_write=1 and the count is < DEPTH: i_wdata goes into the write-pointer slot, and the write pointer advances.
REQ-014 A pop SHALL be accepted on a rising edge when i_read=1 and the count is > 0: the read-pointer slot is loaded into o_rdata, and the read pointer advances.
REQ-015 Read latency SHALL be one cycle: o_rdata is valid in the cycle after the accepting edge and holds its value until the next accepted pop.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 The count SHALL increment on a push-only edge, decrement on a pop-only edge, and stay unchanged when both are accepted on the same edge.
REQ-018 Push while full (count = DEPTH) SHALL be ignored with no state change, even if a pop is accepted on the same edge.
REQ-019 Pop while empty SHALL be ignored: o_rdata holds its value and a simultaneous push is still accepted (no write-to-read bypass).
REQ-020 When count = DEPTH-1 and a push and a pop occur on the same edge, both SHALL be accepted.
REQ-021 o_empty, o_almost_full and o_queued SHALL be derived from the registered count only, with no combinational path from i_write or i_read.
REQ-022 o_almost_full is asserted one entry early so a producer with one registered cycle of write latency cannot overflow; producers SHALL gate writes on it.

Reset
REQ-023 While i_reset=0 the block SHALL asynchronously clear both pointers, the count and o_rdata (to 0), giving o_empty=1, o_almost_full=0 and o_queued=0.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-025 Push or pop requests SHALL be ignored while reset is asserted, and normal operation SHALL begin on the first rising edge after release.

Structure
REQ-026 The block SHALL be a single self-contained module with no shared package, since DEPTH and WIDTH are its only configuration.
REQ-027 The block SHALL have no sub-module; the array is inferred inline as a register or RAM.
REQ-028 Pointer widths SHALL be sized from DEPTH with $clog2, and the count SHALL be 16 bits wide.

Verification
REQ-029 Reset, then no activity (DEPTH=4, WIDTH=32) -> o_empty=1, o_almost_full=0, o_queued=0, o_rdata=0.
REQ-030 Push 0xA1, 0xA2, 0xA3 -> o_queued=3, o_almost_full=1 after the third edge; three pops -> o_rdata=0xA1, 0xA2, 0xA3 each one cycle after its pop, then o_empty=1.
REQ-031 Push 4 words, then push 0xFF -> o_queued stays 4 and the fifth push is lost; four pops return the first 4 words in order.
REQ-032 Pop while empty with o_rdata=0xA3 -> o_rdata stays 0xA3 and o_queued stays 0; pop plus push 0x55 while empty -> o_queued=1, and the next pop yields 0x55.
REQ-033 Sustained simultaneous push/pop for 10 cycles at count=2 -> count stays 2, pointers wrap, data order is preserved.
REQ-034 Assert i_reset=0 asynchronously between clock edges with 3 entries stored -> o_queued=0 and o_empty=1 immediately, without waiting for a clock edge.
